// File: rtl/disp_block_serializer.sv
// disp_block_serializer: snapshots the N-bit board image when a start is
// accepted. It then shifts the image out MSB-first on sclk/sdata and
// finishes with an sload latch pulse.
// Optional build macro DISP_SERIAL_INVERT_EN drives complemented data on
// sdata for active-low LED boards. With that macro the idle, latch and
// reset level of sdata is 1.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; sclk/sload low, sdata at idle level
//   S_SHIFT | shifting snapshot bits N-1..0, CLK_DIV cycles per sclk phase
//   S_LATCH | sload high for CLK_DIV cycles, then done pulse
module disp_block_serializer #(
  parameter int N       = 64,
  parameter int CLK_DIV = 2   // clk cycles per sclk half-period, 1..255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] disp_num,
  input  logic         start,
  output logic         sclk,
  output logic         sdata,
  output logic         sload,
  output logic         busy,
  output logic         done
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_DIV - 1);

`ifdef DISP_SERIAL_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_m1;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;   // 0: sclk low phase, 1: sclk high phase
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             sload_q, sload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic div_tc;
  logic last_bit;

  assign div_tc   = (div_q == DIV_TC);
  assign last_bit = (idx_q == '0);

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= INV;
      sload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sload_q <= sload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (phase_q && div_tc && last_bit) state_d = S_LATCH;
      S_LATCH: if (div_tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    div_d   = div_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    sload_d = sload_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_m1  = idx_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = INV;
        sload_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          snap_d  = disp_num;
          idx_d   = IDX_MAX;
          div_d   = '0;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          sdata_d = disp_num[N-1] ^ INV;
        end
      end
      S_SHIFT: begin
        if (div_tc) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // Falling sclk is the only point where sdata may change.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (last_bit) begin
              sdata_d = INV;
              sload_d = 1'b1;
            end else begin
              idx_d   = idx_m1;
              sdata_d = snap_q[idx_m1] ^ INV;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (div_tc) begin
          div_d   = '0;
          sload_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sdata_d = INV;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        sclk_d  = 1'b0;
        sdata_d = INV;
        sload_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;
  assign sload = sload_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_disp_block_serializer.sv
// Testbench for disp_block_serializer. It runs a default instance with
// CLK_DIV=2 and a second instance with CLK_DIV=1 for the held-start case.
// Expected frames are queued when each start is issued. The monitors pop
// an entry and check the frame whenever a done pulse appears.
module tb_disp_block_serializer;

`ifdef DISP_SERIAL_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [63:0] disp_num, disp_num1;
  logic        start, start1;
  logic        sclk, sdata, sload, busy, done;
  logic        sclk1, sdata1, sload1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb0[$];
  logic [63:0] sb1[$];

  disp_block_serializer #(.N(64), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .disp_num(disp_num), .start(start),
    .sclk(sclk), .sdata(sdata), .sload(sload), .busy(busy), .done(done)
  );

  disp_block_serializer #(.N(64), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .disp_num(disp_num1), .start(start1),
    .sclk(sclk1), .sdata(sdata1), .sload(sload1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor for the CLK_DIV=2 instance.
  logic [63:0] m_word;
  int          m_rises, m_busy, m_sload;
  bit          m_bad, m_psclk, m_psdata, m_pdone;
  always @(negedge clk) begin
    if (!rst) begin
      m_word = '0; m_rises = 0; m_busy = 0; m_sload = 0;
      m_bad = 0; m_psclk = 0; m_psdata = 0; m_pdone = 0;
    end else begin
      if (sclk && !m_psclk) begin
        m_word = {m_word[62:0], sdata};
        m_rises++;
      end
      if (sclk && m_psclk && (sdata !== m_psdata)) m_bad = 1;
      if (busy) m_busy++;
      if (sload) begin
        m_sload++;
        if (sclk) m_bad = 1;
      end
      if (done) begin
        chk("done_width", 64'(m_pdone), 64'd0);
        chk("done_busy_low", 64'(busy), 64'd0);
        if (sb0.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          chk("frame_word", m_word, sb0.pop_front());
          chk("sclk_rises", 64'(m_rises), 64'd64);
          chk("sload_cycles", 64'(m_sload), 64'd2);
          chk("busy_cycles", 64'(m_busy), 64'd258);
          chk("sdata_stable_hi", 64'(m_bad), 64'd0);
        end
        m_word = '0; m_rises = 0; m_busy = 0; m_sload = 0; m_bad = 0;
      end
      m_psclk = sclk; m_psdata = sdata; m_pdone = done;
    end
  end

  // Monitor for the CLK_DIV=1 instance.
  logic [63:0] n_word;
  int          n_busy, n_sload;
  bit          n_psclk;
  always @(negedge clk) begin
    if (!rst) begin
      n_word = '0; n_busy = 0; n_sload = 0; n_psclk = 0;
    end else begin
      if (sclk1 && !n_psclk) n_word = {n_word[62:0], sdata1};
      if (busy1) n_busy++;
      if (sload1) n_sload++;
      if (done1) begin
        if (sb1.size() == 0) begin
          chk("unexpected_done1", 64'd1, 64'd0);
        end else begin
          chk("frame_word1", n_word, sb1.pop_front());
          chk("busy_cycles1", 64'(n_busy), 64'd129);
          chk("sload_cycles1", 64'(n_sload), 64'd1);
        end
        n_word = '0; n_busy = 0; n_sload = 0;
      end
      n_psclk = sclk1;
    end
  end

  task automatic start_frame(input logic [63:0] w);
    disp_num = w;
    start    = 1'b1;
    sb0.push_back(w ^ {64{INV}});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) chk("done_timeout", 64'(n), 64'(budget + 1));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sclk"},  64'(sclk),  64'd0);
    chk({tag, "_sdata"}, 64'(sdata), 64'(INV));
    chk({tag, "_sload"}, 64'(sload), 64'd0);
    chk({tag, "_busy"},  64'(busy),  64'd0);
    chk({tag, "_done"},  64'(done),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done, second_done, ndone;
    logic gap_busy;
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    disp_num = '0; disp_num1 = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_sdata", 64'(sdata), 64'(INV));

    // Single-ended bits, then a mixed pattern.
    start_frame(64'h8000_0000_0000_0001);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(400);
    repeat (3) @(negedge clk);
    start_frame(64'hDEAD_BEEF_0123_4567);
    wait_done(400);
    repeat (2) @(negedge clk);

    // disp_num changes mid-frame do not reach the shifted word.
    start_frame(64'h0123_4567_89AB_CDEF);
    repeat (40) @(negedge clk);
    disp_num = 64'h0;
    wait_done(400);
    repeat (2) @(negedge clk);

    // A start pulse during the frame is ignored and not queued.
    start_frame(64'hA5A5_5A5A_F00F_0FF0);
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    repeat (5) @(negedge clk);
    chk("start_not_queued", 64'(busy), 64'd0);

    // Asynchronous reset mid-shift, off the clock edge.
    start_frame(64'hCAFE_F00D_1234_5678);
    repeat (77) @(negedge clk);
    #2;
    rst = 1'b0;
    sb0.delete();
    #1;
    chk_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_frame(64'h0F0F_3C3C_FFFF_FFFE);
    wait_done(400);
    repeat (2) @(negedge clk);

    // Back-to-back frames with start held through the done cycle.
    disp_num = 64'h1357_9BDF_2468_ACE0;
    sb0.push_back(64'h1357_9BDF_2468_ACE0 ^ {64{INV}});
    sb0.push_back(64'h1357_9BDF_2468_ACE0 ^ {64{INV}});
    start = 1'b1;
    wait_done(400);
    @(negedge clk);
    chk("b2b_restart", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);

    // Start held high on the CLK_DIV=1 instance.
    disp_num1 = 64'hFFFF_0000_FFFF_0000;
    sb1.push_back(64'hFFFF_0000_FFFF_0000 ^ {64{INV}});
    sb1.push_back(64'hFFFF_0000_FFFF_0000 ^ {64{INV}});
    start1 = 1'b1;
    first_done = 0; second_done = 0; ndone = 0; gap_busy = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (ndone == 1) first_done = i;
        else second_done = i;
      end
      if (i == 131) gap_busy = busy1;
    end
    start1 = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd2);
    chk("held_first_done", 64'(first_done), 64'd130);
    chk("held_second_done", 64'(second_done), 64'd260);
    chk("held_gap_restart", 64'(gap_busy), 64'd1);

    repeat (300) @(negedge clk);
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    chk("final_idle_busy1", 64'(busy1), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_block_serializer.md
Name: disp_block_serializer

Overview:
- Consumer side of the block generator's 64-bit `Disp_num` board image.
- Snapshots the image on request and shifts it out MSB-first on a serial clock/data/latch interface to the cascaded shift-register LED board.
- One frame per accepted start. The game top-level issues `start` on each generator update, or on a refresh tick.

Parameters:
- N, 64: width of the display image in bits.
- CLK_DIV, 2: `clk` cycles per `sclk` half-period; legal range 1..255.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `disp_num`  input  N  board image from the block generator; sampled only when a start is accepted.
- `start`  input  1  frame request; level-sampled each cycle.
- `sclk`  output  1  serial shift clock to the LED shift registers.
- `sdata`  output  1  serial data; stable whenever `sclk` is high.
- `sload`  output  1  storage-register latch pulse, active-high.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (`rst`=0, asynchronous): state IDLE, `sclk`=0, `sdata`=0, `sload`=0, `busy`=0, `done`=0, snapshot register cleared, counters 0. Reset mid-frame aborts the frame immediately. No `sload` or `done` is issued for an aborted frame.
- States:
  - IDLE → SHIFT on `start`=1.
  - SHIFT → LATCH after the high phase of bit 0.
  - LATCH → IDLE after CLK_DIV cycles.
- Start accept (rising edge where state=IDLE and `start`=1):
  - Snapshot <= `disp_num`; bit index <= N-1; div counter <= 0.
  - From the next cycle: `busy`=1, `sclk`=0, `sdata`=snapshot[N-1].
- SHIFT, per bit:
  - `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At the end of the high phase, `sclk` goes low and the bit index decrements. `sdata` presents the next bit in that same cycle, so data changes only while `sclk` falls.
  - Bit order: N-1 down to 0.
- LATCH:
  - `sclk`=0, `sdata`=0, `sload`=1 for exactly CLK_DIV cycles.
- Frame end:
  - On the cycle after LATCH: state IDLE, `busy`=0, `done`=1 for one cycle.
  - `busy` is high for exactly 2·N·CLK_DIV + CLK_DIV cycles. This is 258 cycles at the defaults.
- Start while busy: ignored and not queued.
- Start in the `done` cycle: accepted, because the state is IDLE. This gives back-to-back frames with a 1-cycle `busy` gap.
- Start held high continuously: frames repeat with a 1-cycle gap.
- `disp_num` changes during a frame: no effect on the frame in progress. Only the snapshot is shifted.
- Counter wrap: the bit index and div counter never wrap outside their defined ranges. The bit index is sized ceil(log2 N), the div counter ceil(log2(CLK_DIV+1)).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: `DISP_SERIAL_INVERT_EN`.
- Defined: `sdata` carries the complement of each snapshot bit, for active-low LED boards. Idle/LATCH/reset value of `sdata` becomes 1.
- Not defined: `sdata` carries true data, idle value 0.
- Timing, `sload`, `busy` and `done` are identical in both builds.

Test Plan:
- `disp_num`=64'h8000_0000_0000_0001, one start, CLK_DIV=2:
  - `sdata`=1 during the first and last `sclk` high phases, 0 otherwise.
  - 64 `sclk` rising edges, `sload` high 2 cycles.
  - `done` pulses 258 cycles after `busy` rises.
- `disp_num`=64'hDEAD_BEEF_0123_4567: bench samples `sdata` on each `sclk` rise. The collected 64 bits equal 64'hDEAD_BEEF_0123_4567.
- Mid-frame changes:
  - Start, then change `disp_num` to 64'h0 after 40 cycles → shifted word is still the original.
  - Pulse `start` at cycle 100 of the frame → ignored: no restart, and `busy` length is unchanged.
- Reset during SHIFT: drive `rst`=0 asynchronously mid-frame (not edge-aligned) → all outputs 0 immediately, with no `sload` or `done`. After release plus a start, a clean full frame follows.
- `start` held high, CLK_DIV=1:
  - Consecutive frames, each `busy`=129 cycles, separated by exactly one `done` cycle with `busy`=0.
  - Two `done` pulses within 260 cycles.
- `DISP_SERIAL_INVERT_EN` defined, `disp_num`=64'hFFFF_0000_FFFF_0000:
  - Sampled stream is 64'h0000_FFFF_0000_FFFF.
  - `sdata`=1 in idle and after reset.
